outr_serial_tx: RTL
===================

Name: outr_serial_tx

Overview:
- Output-device stage directly downstream of the 8-bit output register (OUTR) in the basic computer.
- When the control unit loads OUTR, this block takes the 8-bit character, owns the FGO (output-ready) flag, and sends the character on a serial line as 8N1 frames (1 start bit, 8 data bits, 1 stop bit).
- It reports ready again (FGO=1) once the stop bit has finished.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- out_load  input  1  the same load strobe the control unit drives into OUTR.
- out_data  input  8  registered OUTR contents.
- fgo  output  1  output flag; 1 = device ready for a new character.
- busy  output  1  1 while a frame is being sent (state is not IDLE).
- tx  output  1  serial line; idles high.
- err_overrun  output  1  one-cycle pulse when out_load arrives while fgo=0.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE, tx=1, fgo=1, busy=0, err_overrun=0.
  - pending=0; bit counter, cycle counter and shift register cleared.
  - Release from reset is synchronous to clk.
- Why there is a pending flag: OUTR registers out_data on the same edge that samples out_load, so out_data is only valid one cycle later. The block keeps an internal pending flag to bridge that cycle.
- Edge k, out_load=1 and fgo=1:
  - pending<=1, fgo<=0.
- Edge k, out_load=1 and fgo=0:
  - The load is ignored: pending, fgo and the frame in progress are unchanged.
  - err_overrun<=1 for exactly one cycle.
- Edge k+1, state=IDLE and pending=1:
  - shift<=out_data, pending<=0, state<=START, tx<=0, cycle counter<=0.
- State machine IDLE -> START -> DATA -> STOP -> IDLE:
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right on each bit boundary; the bit index counts 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle: state<=IDLE, fgo<=1.
- Timing:
  - tx is registered and changes only on bit boundaries.
  - The frame lasts exactly 10*CLKS_PER_BIT cycles, starting at edge k+1.
  - fgo rises at edge k+1+10*CLKS_PER_BIT.
  - busy=1 from edge k+1 until the same edge where fgo rises.
- Back-to-back: out_load is accepted on the first cycle fgo reads 1. No idle gap is required beyond the pending cycle.
- Cycle counter:
  - Wraps to 0 at CLKS_PER_BIT-1.
  - Width is ceil(log2(CLKS_PER_BIT)), minimum 1.
  - No off-by-one is allowed: every bit is exactly CLKS_PER_BIT cycles long.
- out_data is sampled only at the capture edge. Changes at any other time do not affect the frame.
- out_load held high for several cycles: only the first edge is accepted. Later edges see fgo=0 and each one pulses err_overrun.

Test Plan:
- Reset value check:
  - Stimulus: assert rst mid-DATA of a frame (CLKS_PER_BIT=4).
  - Required: tx=1, fgo=1 and busy=0 immediately, without waiting for a clk edge.
  - Then: after release, the next out_load produces a clean full frame.
- Single character:
  - Stimulus: CLKS_PER_BIT=4, out_load for 1 cycle, out_data=0x41.
  - Required tx bit sequence, 4 cycles each: 0 | 1,0,0,0,0,0,1,0 | 1.
  - Required flags: fgo=0 for 41 cycles after the load edge; busy high for 40 cycles.
- Back-to-back characters:
  - Stimulus: send 0xFF, then load 0x00 on the first cycle fgo=1.
  - Required: the second frame starts 1 cycle after its load; no extra idle bits; err_overrun never pulses.
- Overrun:
  - Stimulus: load 0x55, then load 0xAA 10 cycles later.
  - Required: err_overrun is high for exactly 1 cycle; the 0x55 frame is transmitted unaltered; 0xAA is never sent.
- Data stability:
  - Stimulus: load 0x3C, then change out_data to 0xC3 during the DATA state.
  - Required: the serialized bits still equal 0x3C.
- Minimum divider:
  - Stimulus: CLKS_PER_BIT=2, send 0x80.
  - Required: frame is exactly 20 cycles; tx is low for 16 cycles (start + 7 zero bits) and high for 4 cycles (bit7 + stop).

Source files
------------

// File: rtl/outr_serial_tx.sv
// outr_serial_tx
//   Output-device stage behind the 8-bit OUTR register. It owns the FGO
//   (output-ready) flag. It serialises each loaded character as an 8N1 frame:
//   one start bit, eight data bits sent LSB first, and one stop bit.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   out_load     OUTR load strobe from the control unit
//   out_data     registered OUTR contents (valid the cycle after out_load)
//   fgo          1 = ready for a new character
//   busy         1 while a frame is in progress
//   tx           serial line, idles high
//   err_overrun  one-cycle pulse when out_load arrives while fgo=0
module outr_serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_load,
  input  logic [7:0] out_data,
  output logic       fgo,
  output logic       busy,
  output logic       tx,
  output logic       err_overrun
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic          pending;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_r;
  logic          fgo_r;
  logic          ovr_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_r    <= 1'b1;
      fgo_r   <= 1'b1;
      ovr_r   <= 1'b0;
    end else begin
      ovr_r <= out_load & ~fgo_r;

      // out_data is only valid one cycle after the load strobe, so the load
      // is remembered in pending and the character is captured from IDLE.
      if (out_load && fgo_r) begin
        pending <= 1'b1;
        fgo_r   <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (pending) begin
            shift   <= out_data;
            pending <= 1'b0;
            state   <= START;
            tx_r    <= 1'b0;
            cnt     <= '0;
          end
        end

        START: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_r    <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // tx already holds the current bit; shift[0] is always the next one.
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_r  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_r    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            fgo_r <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign fgo         = fgo_r;
  assign busy        = (state != IDLE);
  assign tx          = tx_r;
  assign err_overrun = ovr_r;

endmodule
